// File: rtl/fmul_pkg.sv
// Shared FMUL definitions: IEEE-754 single constants, field widths and the
// payload carried from the normalize register to the round/pack register.
package fmul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int PROD_W = 48;
  localparam int SUM_W  = 10;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef enum logic [1:0] {
    KIND_ARITH,
    KIND_PRIMAL,
    KIND_ERROR
  } kind_e;

  // One extra exponent bit so the +1 from normalize and rounding never wraps.
  typedef struct packed {
    logic              sign;
    logic [FRAC_W-1:0] mant;
    logic              g;
    logic              s;
    logic [SUM_W:0]    exp;
    logic [31:0]       bypass;
    kind_e             kind;
  } s1_payload_t;

endpackage

// File: rtl/fmul_rne_round.sv
// Combinational round-to-nearest-even, overflow/underflow detection and
// packing of a normalized stage-1 payload.
module fmul_rne_round
  import fmul_pkg::*;
(
  input  s1_payload_t payload,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        error
);

  logic              round_up;
  logic [FRAC_W:0]   mant_sum;
  logic [SUM_W:0]    exp_rnd;

  assign round_up = payload.g & (payload.s | payload.mant[0]);
  assign mant_sum = {1'b0, payload.mant} + {{FRAC_W{1'b0}}, round_up};
  // A carry out of the fraction leaves mant_sum[22:0] all zero, so only the exponent moves.
  assign exp_rnd  = payload.exp + {{SUM_W{1'b0}}, mant_sum[FRAC_W]};

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = 1'b0;
    error     = 1'b0;
    case (payload.kind)
      KIND_ERROR: begin
        result = QNAN;
        error  = 1'b1;
      end
      KIND_PRIMAL: begin
        result = payload.bypass;
      end
      default: begin
        inexact = payload.g | payload.s;
        if ($signed(exp_rnd) >= $signed((SUM_W+1)'(EXP_MAX))) begin
          result   = {payload.sign, 8'hFF, {FRAC_W{1'b0}}};
          overflow = 1'b1;
          inexact  = 1'b1;
        end else if ($signed(exp_rnd) <= $signed((SUM_W+1)'(0))) begin
          result    = {payload.sign, 31'b0};
          underflow = 1'b1;
          inexact   = 1'b1;
        end else begin
          result = {payload.sign, exp_rnd[EXP_W-1:0], mant_sum[FRAC_W-1:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/fmul_round_pack.sv
// Final FMUL stage: normalize into a first register, round/pack into a second,
// with valid/ready backpressure through both slots.
module fmul_round_pack
  import fmul_pkg::*;
#(
  parameter int FTZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        a_sign,
  input  logic        a_primal,
  input  logic [7:0]  a_primal_exp,
  input  logic [22:0] a_primal_frac,
  input  logic        a_error,
  input  logic [47:0] a_partial_frac,
  input  logic [9:0]  a_exp_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        error
);

  if (FTZ != 1) begin : g_bad_ftz
    $error("fmul_round_pack: only FTZ=1 is supported");
  end

  s1_payload_t    norm;
  s1_payload_t    s1;
  logic           s1_valid;
  logic           s2_valid;
  logic           s2_advance;
  logic [SUM_W:0] exp_ext;

  logic [31:0] rnd_result;
  logic        rnd_overflow;
  logic        rnd_underflow;
  logic        rnd_inexact;
  logic        rnd_error;

  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_valid  = s2_valid;
  assign exp_ext    = {a_exp_sum[SUM_W-1], a_exp_sum};

  // A product without a leading one in bit 47 or 46 is illegal upstream; it packs as signed zero.
  always_comb begin
    norm      = '0;
    norm.sign = a_sign;
    if (a_error) begin
      norm.kind   = KIND_ERROR;
      norm.bypass = QNAN;
    end else if (a_primal) begin
      norm.kind   = KIND_PRIMAL;
      norm.bypass = {a_sign, a_primal_exp, a_primal_frac};
    end else if (a_partial_frac[47]) begin
      norm.kind = KIND_ARITH;
      norm.mant = a_partial_frac[46:24];
      norm.g    = a_partial_frac[23];
      norm.s    = |a_partial_frac[22:0];
      norm.exp  = exp_ext + (SUM_W+1)'(1);
    end else if (a_partial_frac[46]) begin
      norm.kind = KIND_ARITH;
      norm.mant = a_partial_frac[45:23];
      norm.g    = a_partial_frac[22];
      norm.s    = |a_partial_frac[21:0];
      norm.exp  = exp_ext;
    end else begin
      norm.kind   = KIND_PRIMAL;
      norm.bypass = {a_sign, 31'b0};
    end
  end

  fmul_rne_round u_round (
    .payload   (s1),
    .result    (rnd_result),
    .overflow  (rnd_overflow),
    .underflow (rnd_underflow),
    .inexact   (rnd_inexact),
    .error     (rnd_error)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      s2_valid  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= norm;
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result    <= rnd_result;
          overflow  <= rnd_overflow;
          underflow <= rnd_underflow;
          inexact   <= rnd_inexact;
          error     <= rnd_error;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmul_round_pack.sv
// Randomized and directed bench for fmul_round_pack, scored against an
// arithmetic reference model of the round-to-nearest-even packing.
module tb_fmul_round_pack;

  typedef struct {
    logic        sign;
    logic        primal;
    logic        err;
    logic [7:0]  pexp;
    logic [22:0] pfrac;
    logic [47:0] p;
    logic [9:0]  es;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        a_sign;
  logic        a_primal;
  logic [7:0]  a_primal_exp;
  logic [22:0] a_primal_frac;
  logic        a_error;
  logic [47:0] a_partial_frac;
  logic [9:0]  a_exp_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [35:0] exp_q[$];
  string       tag_q[$];
  item_t       cur;
  string       cur_tag;
  logic        use_override;
  logic [35:0] override_exp;
  logic        accepted;
  logic        rand_ready;

  fmul_round_pack #(.FTZ(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_sign         (a_sign),
    .a_primal       (a_primal),
    .a_primal_exp   (a_primal_exp),
    .a_primal_frac  (a_primal_frac),
    .a_error        (a_error),
    .a_partial_frac (a_partial_frac),
    .a_exp_sum      (a_exp_sum),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .overflow       (overflow),
    .underflow      (underflow),
    .inexact        (inexact),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference: treat P as an integer, shift to a 24-bit significand and round the remainder.
  function automatic logic [35:0] model(item_t it);
    longint unsigned p, m, rem, half;
    int sh, e;
    logic up, inx;
    if (it.err) return {32'h7FC00000, 4'b0001};
    if (it.primal) return {it.sign, it.pexp, it.pfrac, 4'b0000};
    p    = 64'(it.p);
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || (rem == half && m[0]);
    m    = m + 64'(up);
    e    = int'($signed(it.es)) + (sh - 23);
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    inx = (rem != 0);
    if (e >= 255) return {it.sign, 8'hFF, 23'd0, 4'b1010};
    if (e <= 0) return {it.sign, 31'd0, 4'b0110};
    return {it.sign, 8'(e), m[22:0], 1'b0, 1'b0, inx, 1'b0};
  endfunction

  function automatic item_t arith(input logic [47:0] p, input logic [9:0] es);
    item_t it;
    it.sign = 1'b0; it.primal = 1'b0; it.err = 1'b0;
    it.pexp = 8'd0; it.pfrac = 23'd0; it.p = p; it.es = es;
    return it;
  endfunction

  function automatic item_t random_item();
    item_t it;
    logic [63:0] raw;
    int r;
    raw = {$urandom, $urandom};
    it.p = raw[47:0];
    if (it.p[47:46] == 2'b00) it.p[46] = 1'b1;
    if ($urandom_range(0, 7) == 0) it.p[21:0] = '0;
    r = int'($urandom_range(0, 300)) - 30;
    it.es     = 10'(r);
    it.sign   = 1'($urandom);
    it.err    = ($urandom_range(0, 15) == 0);
    it.primal = ($urandom_range(0, 15) == 0);
    it.pexp   = 8'($urandom);
    it.pfrac  = 23'($urandom);
    return it;
  endfunction

  task automatic applyStimulus(input item_t it, input string tag);
    cur            = it;
    cur_tag        = tag;
    a_sign         = it.sign;
    a_primal       = it.primal;
    a_error        = it.err;
    a_primal_exp   = it.pexp;
    a_primal_frac  = it.pfrac;
    a_partial_frac = it.p;
    a_exp_sum      = it.es;
    in_valid       = 1'b1;
  endtask

  // One clock: called at a negedge, observes handshakes just before the posedge, returns at the next negedge.
  task automatic cycle();
    logic [35:0] want;
    string t;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checkOutput(t, {28'd0, result, overflow, underflow, inexact, error}, {28'd0, want});
      end
    end
    if (accepted) begin
      exp_q.push_back(use_override ? override_exp : model(cur));
      tag_q.push_back(cur_tag);
    end
    @(negedge clk);
  endtask

  task automatic send(input item_t it, input string tag);
    applyStimulus(it, tag);
    accepted = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) cycle();
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic sendDirected(input item_t it, input logic [35:0] want, input string tag);
    use_override = 1'b1;
    override_exp = want;
    send(it, tag);
    use_override = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) cycle();
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    item_t bp_items[4];
    item_t it;
    int idx;
    logic [31:0] held;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rand_ready = 1'b0;
    use_override = 1'b0; override_exp = '0; accepted = 1'b0; cur_tag = "";
    applyStimulus(arith(48'h400000000000, 10'd127), "init");
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_flags", 64'({overflow, underflow, inexact, error}), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Latency: one item with out_ready high appears two edges after acceptance.
    use_override = 1'b1;
    override_exp = {32'h3F800000, 4'b0000};
    applyStimulus(arith(48'h400000000000, 10'd127), "one_point_zero");
    cycle();
    in_valid = 1'b0;
    use_override = 1'b0;
    checkOutput("lat_edge1", 64'(out_valid), 64'd0);
    cycle();
    checkOutput("lat_edge2", 64'(out_valid), 64'd1);
    drain();

    sendDirected(arith(48'h900000000000, 10'd127), {32'h40100000, 4'b0000}, "two_point_25");
    sendDirected(arith(48'h400000400000, 10'd127), {32'h3F800000, 4'b0010}, "tie_even_hold");
    sendDirected(arith(48'h400000C00000, 10'd127), {32'h3F800002, 4'b0010}, "tie_odd_up");
    sendDirected(arith(48'h7FFFFFC00000, 10'd127), {32'h40000000, 4'b0010}, "round_carry");
    sendDirected(arith(48'h800000000000, 10'd254), {32'h7F800000, 4'b1010}, "overflow");
    sendDirected(arith(48'h400000000000, 10'h3FB), {32'h00000000, 4'b0110}, "underflow");
    it = arith(48'h400000000000, 10'd127); it.err = 1'b1;
    sendDirected(it, {32'h7FC00000, 4'b0001}, "error_qnan");
    it = arith(48'h400000000000, 10'd127); it.primal = 1'b1; it.sign = 1'b1; it.pexp = 8'hFF;
    sendDirected(it, {32'hFF800000, 4'b0000}, "primal_neg_inf");
    drain();

    // Backpressure: with the consumer stalled only two of four offers fit.
    for (int i = 0; i < 4; i++) bp_items[i] = random_item();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(bp_items[idx], "bp_item");
      cycle();
      if (accepted) idx++;
    end
    checkOutput("bp_accepts", 64'(idx), 64'd2);
    #1;
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    held = result;
    @(negedge clk);
    cycle();
    cycle();
    checkOutput("bp_result_stable", 64'(result), 64'(held));
    out_ready = 1'b1;
    for (int n = 0; n < 50 && idx < 4; n++) begin
      applyStimulus(bp_items[idx], "bp_item");
      cycle();
      if (accepted) idx++;
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    drain();

    // Reset mid-stream: in-flight items vanish immediately and never reappear.
    applyStimulus(random_item(), "pre_reset");
    cycle();
    applyStimulus(random_item(), "pre_reset");
    cycle();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_drop", 64'(out_valid), 64'd0);
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) cycle();
    checkOutput("post_rst_idle", 64'(out_valid), 64'd0);

    // Random traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) send(random_item(), "random");
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
